// File: rtl/mii_rx_frame_if.sv
// mii_rx_frame_if: MII receive inputs plus RAM write port and frame status outputs.
interface mii_rx_frame_if;
    logic [3:0]  MII_RXD;
    logic        MII_RXDV;
    logic [10:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_wr;
    logic [10:0] frame_len;
    logic        frame_done;
    logic        crc_ok;
    logic        frame_err;
    logic        busy;
    modport master (
        input  MII_RXD, MII_RXDV,
        output ram_addr, ram_data, ram_wr, frame_len, frame_done, crc_ok, frame_err, busy
    );
    modport slave (
        output MII_RXD, MII_RXDV,
        input  ram_addr, ram_data, ram_wr, frame_len, frame_done, crc_ok, frame_err, busy
    );
endinterface

// File: rtl/mii_rx_frame.sv
// mii_rx_frame: MII nibble receiver that writes frame bytes to RAM and validates the FCS.
module mii_rx_frame #(
    parameter int MAX_LEN = 1518
) (
    input logic clk,
    input logic reset,
    mii_rx_frame_if.master m
);
    localparam logic [10:0] MAX = 11'(MAX_LEN);
    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, CHECK, DROP} state_t;
    state_t      state;
    logic [31:0] crc;
    logic [10:0] cnt;
    logic [3:0]  low;
    logic        hi;
    logic        wait_low;
    logic [7:0]  byte_in;
    logic        good;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
        return r;
    endfunction

    assign byte_in = {m.MII_RXD, low};
    assign good    = crc == 32'hDEBB20E3 && cnt >= 11'd5 && !hi;
    assign m.busy  = state != IDLE;

    // wait_low masks the tail of a frame that was cut short by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            crc          <= '1;
            cnt          <= '0;
            low          <= '0;
            hi           <= 1'b0;
            wait_low     <= 1'b1;
            m.ram_addr   <= '0;
            m.ram_data   <= '0;
            m.ram_wr     <= 1'b0;
            m.frame_len  <= '0;
            m.frame_done <= 1'b0;
            m.crc_ok     <= 1'b0;
            m.frame_err  <= 1'b0;
        end else begin
            m.ram_wr     <= 1'b0;
            m.frame_done <= 1'b0;
            wait_low     <= wait_low && m.MII_RXDV;
            case (state)
                IDLE, CHECK: begin
                    cnt   <= '0;
                    hi    <= 1'b0;
                    crc   <= '1;
                    state <= m.MII_RXDV && !wait_low ? (m.MII_RXD == 4'h5 ? PREAMBLE : DROP) : IDLE;
                end
                PREAMBLE: begin
                    if (!m.MII_RXDV) state <= IDLE;
                    else if (m.MII_RXD == 4'hD) state <= DATA;
                    else if (m.MII_RXD != 4'h5) state <= DROP;
                end
                DATA: begin
                    if (!m.MII_RXDV) begin
                        state        <= CHECK;
                        m.frame_done <= 1'b1;
                        m.frame_len  <= cnt;
                        m.crc_ok     <= good;
                        m.frame_err  <= !good;
                    end else if (!hi) begin
                        low <= m.MII_RXD;
                        hi  <= 1'b1;
                    end else if (cnt == MAX) begin
                        state <= DROP;
                    end else begin
                        hi         <= 1'b0;
                        m.ram_wr   <= 1'b1;
                        m.ram_data <= byte_in;
                        m.ram_addr <= cnt;
                        cnt        <= cnt + 11'd1;
                        crc        <= crc_next(crc, byte_in);
                    end
                end
                DROP: begin
                    if (!m.MII_RXDV) begin
                        state        <= IDLE;
                        m.frame_done <= 1'b1;
                        m.frame_len  <= cnt;
                        m.crc_ok     <= 1'b0;
                        m.frame_err  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mii_rx_frame.sv
// tb_mii_rx_frame: table-driven frame vectors plus back-to-back and mid-frame reset sequences.
module tb_mii_rx_frame;
    logic clk = 1'b0;
    logic reset;
    logic [3:0] rxd;
    logic rxdv;
    always #5 clk = ~clk;

    mii_rx_frame_if bus ();
    mii_rx_frame_if bus16 ();
    assign bus.MII_RXD    = rxd;
    assign bus.MII_RXDV   = rxdv;
    assign bus16.MII_RXD  = rxd;
    assign bus16.MII_RXDV = rxdv;

    mii_rx_frame dut (.clk(clk), .reset(reset), .m(bus));
    mii_rx_frame #(.MAX_LEN(16)) dut16 (.clk(clk), .reset(reset), .m(bus16));

    typedef struct {
        string name;
        int    kind;
        int    wr;
        int    len;
        bit    ok;
        bit    err;
        bit    done;
    } vec_t;

    localparam logic [7:0] GOOD [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                         8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    localparam logic [7:0] MIN5 [5] = '{8'h61, 8'h43, 8'hBE, 8'hB7, 8'hE8};

    logic [7:0] fq[$];
    int checks = 0, errors = 0;
    int nwr = 0, dn = 0, addr_bad = 0, data_bad = 0, wr_idle = 0, na = 0;
    int nwr16 = 0, dn16 = 0, bad16 = 0, na16 = 0;

    always @(negedge clk) begin
        if (!reset) begin
            na = 0;
            na16 = 0;
        end
        if (bus.ram_wr) begin
            nwr++;
            if (!bus.busy) wr_idle++;
            if (int'(bus.ram_addr) != na) addr_bad++;
            if (int'(bus.ram_addr) >= fq.size() || bus.ram_data != fq[bus.ram_addr]) data_bad++;
            na = int'(bus.ram_addr) + 1;
        end
        if (bus.frame_done) begin
            dn++;
            na = 0;
        end
        if (bus16.ram_wr) begin
            nwr16++;
            if (int'(bus16.ram_addr) != na16) bad16++;
            if (int'(bus16.ram_addr) >= fq.size() || bus16.ram_data != fq[bus16.ram_addr]) bad16++;
            na16 = int'(bus16.ram_addr) + 1;
        end
        if (bus16.frame_done) begin
            dn16++;
            na16 = 0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic nib(input logic [3:0] n);
        rxd = n;
        rxdv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        rxdv = 1'b0;
        rxd = 4'h0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic body(input int kind);
        fq.delete();
        if (kind == 4) repeat (4) fq.push_back(8'h00);
        else if (kind == 7) for (int i = 0; i < 20; i++) fq.push_back(8'(i));
        else if (kind == 8) for (int i = 0; i < 5; i++) fq.push_back(MIN5[i]);
        else if (kind != 5) for (int i = 0; i < 13; i++) fq.push_back(GOOD[i]);
        if (kind == 1) fq[4] = 8'h34;
        if (kind == 3) begin
            nib(4'h5); nib(4'h5); nib(4'h7);
        end else if (kind == 5) begin
            nib(4'h5); nib(4'h5); nib(4'h5);
        end else if (kind == 6) begin
            nib(4'h3);
        end else begin
            repeat (15) nib(4'h5);
            nib(4'hD);
        end
        foreach (fq[i]) begin
            nib(fq[i][3:0]);
            nib(fq[i][7:4]);
        end
        if (kind == 2) nib(4'hA);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ram_addr"}, 32'(bus.ram_addr), 0);
        check({tag, ".ram_data"}, 32'(bus.ram_data), 0);
        check({tag, ".ram_wr"}, 32'(bus.ram_wr), 0);
        check({tag, ".frame_len"}, 32'(bus.frame_len), 0);
        check({tag, ".frame_done"}, 32'(bus.frame_done), 0);
        check({tag, ".crc_ok"}, 32'(bus.crc_ok), 0);
        check({tag, ".frame_err"}, 32'(bus.frame_err), 0);
        check({tag, ".busy"}, 32'(bus.busy), 0);
    endtask

    task automatic run(input vec_t v);
        int d0, e0, w0, a0, b0, i0, w16, b16;
        d0 = dn; e0 = dn16; w0 = nwr; a0 = addr_bad; b0 = data_bad; i0 = wr_idle;
        w16 = nwr16; b16 = bad16;
        body(v.kind);
        check({v.name, ".early_done"}, dn - d0, 0);
        check({v.name, ".early_done16"}, dn16 - e0, 0);
        gap(6);
        check({v.name, ".writes"}, nwr - w0, v.wr);
        check({v.name, ".done_pulses"}, dn - d0, 32'(v.done));
        check({v.name, ".addr_seq"}, addr_bad - a0, 0);
        check({v.name, ".wr_data"}, data_bad - b0, 0);
        check({v.name, ".wr_outside"}, wr_idle - i0, 0);
        check({v.name, ".busy"}, 32'(bus.busy), 0);
        if (v.done) begin
            check({v.name, ".frame_len"}, 32'(bus.frame_len), v.len);
            check({v.name, ".crc_ok"}, 32'(bus.crc_ok), 32'(v.ok));
            check({v.name, ".frame_err"}, 32'(bus.frame_err), 32'(v.err));
        end
        if (v.wr > 0) check({v.name, ".addr_hold"}, 32'(bus.ram_addr), v.wr - 1);
        if (v.kind == 7) begin
            check("max16.writes", nwr16 - w16, 16);
            check("max16.done_pulses", dn16 - e0, 1);
            check("max16.frame_len", 32'(bus16.frame_len), 16);
            check("max16.frame_err", 32'(bus16.frame_err), 1);
            check("max16.crc_ok", 32'(bus16.crc_ok), 0);
            check("max16.wr_seq", bad16 - b16, 0);
            check("max16.addr_hold", 32'(bus16.ram_addr), 15);
        end
    endtask

    vec_t vt[9];
    int d0, w0, a0, b0;

    initial begin
        vt[0] = '{"good",         0, 13, 13, 1'b1, 1'b0, 1'b1};
        vt[1] = '{"corrupt",      1, 13, 13, 1'b0, 1'b1, 1'b1};
        vt[2] = '{"odd_nibble",   2, 13, 13, 1'b0, 1'b1, 1'b1};
        vt[3] = '{"bad_preamble", 3,  0,  0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{"short4",       4,  4,  4, 1'b0, 1'b1, 1'b1};
        vt[5] = '{"pre_abort",    5,  0,  0, 1'b0, 1'b0, 1'b0};
        vt[6] = '{"idle_drop",    6,  0,  0, 1'b0, 1'b1, 1'b1};
        vt[7] = '{"maxlen",       7, 20, 20, 1'b0, 1'b1, 1'b1};
        vt[8] = '{"min5",         8,  5,  5, 1'b1, 1'b0, 1'b1};

        reset = 1'b0;
        rxd = 4'h0;
        rxdv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 reset = 1'b1;
        gap(2);

        foreach (vt[i]) run(vt[i]);

        d0 = dn; w0 = nwr; a0 = addr_bad; b0 = data_bad;
        body(0);
        gap(1);
        body(0);
        gap(6);
        check("b2b.done_pulses", dn - d0, 2);
        check("b2b.writes", nwr - w0, 26);
        check("b2b.addr_seq", addr_bad - a0, 0);
        check("b2b.wr_data", data_bad - b0, 0);
        check("b2b.frame_len", 32'(bus.frame_len), 13);
        check("b2b.crc_ok", 32'(bus.crc_ok), 1);

        d0 = dn;
        fq.delete();
        for (int i = 0; i < 13; i++) fq.push_back(GOOD[i]);
        repeat (15) nib(4'h5);
        nib(4'hD);
        for (int i = 0; i < 4; i++) begin
            nib(fq[i][3:0]);
            nib(fq[i][7:4]);
        end
        nib(fq[4][3:0]);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        w0 = nwr;
        nib(fq[4][7:4]);
        check("post_reset.busy", 32'(bus.busy), 0);
        for (int i = 5; i < 13; i++) begin
            nib(fq[i][3:0]);
            nib(fq[i][7:4]);
        end
        gap(6);
        check("post_reset.done_pulses", dn - d0, 0);
        check("post_reset.writes", nwr - w0, 0);
        run(vt[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mii_rx_frame.md
MII_RX_FRAME -- requirements
Module: mii_rx_frame

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, the maximum accepted frame bytes including FCS (max 2047).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port MII_RXD  input  4  receive nibble, sampled each clk.
REQ-005 SHALL have port MII_RXDV  input  1  receive data valid.
REQ-006 SHALL have port ram_addr  output  11  byte write address.
REQ-007 SHALL have port ram_data  output  8  byte write data.
REQ-008 SHALL have port ram_wr  output  1  one-cycle write strobe.
REQ-009 SHALL have port frame_len  output  11  byte count of last frame, FCS included.
REQ-010 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-011 SHALL have port crc_ok  output  1  last frame FCS valid; held until next frame_done.
REQ-012 SHALL have port frame_err  output  1  last frame had an error; held until next frame_done.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, DATA, CHECK, DROP.
REQ-015 SHALL go IDLE->PREAMBLE when MII_RXDV=1 and MII_RXD=0x5; IDLE->DROP when MII_RXDV=1 and any other nibble.
REQ-016 In PREAMBLE: 0x5 stays; 0xD after at least one 0x5 goes to DATA; any other nibble goes to DROP; MII_RXDV=0 goes to IDLE with no frame_done.
REQ-017 In DATA: the first nibble of each pair is the low nibble, the second the high nibble; byte = {high, low}.
REQ-018 SHALL assert ram_wr for exactly one cycle, the cycle after the high nibble is sampled, with ram_data = byte and ram_addr = byte index from 0.
REQ-019 SHALL compute reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF, no final XOR) over every DATA byte, FCS included, one byte per write.
REQ-020 DATA->CHECK when MII_RXDV falls; DATA->DROP with error flagged when byte count would exceed MAX_LEN (that byte is not written).
REQ-021 CHECK (one cycle): frame_done=1; frame_len=byte count; crc_ok=1 iff CRC register = 0xDEBB20E3, byte count >= 5 and nibble count even; frame_err=!crc_ok; then IDLE.
REQ-022 DROP: no writes; waits for MII_RXDV=0, then pulses frame_done with crc_ok=0, frame_err=1, frame_len=bytes written so far, then IDLE. A DROP entered from IDLE counts 0 bytes.
REQ-023 Odd nibble count at MII_RXDV fall: the dangling nibble is discarded and frame_err=1.
REQ-024 MII_RXDV rising in the same cycle as frame_done SHALL be handled as in IDLE (no lost start).
REQ-025 ram_addr SHALL hold its last value between writes; ram_wr SHALL never assert outside DATA.

Reset
REQ-026 While reset=0 at a clk edge: state IDLE, ram_addr=0, ram_data=0, ram_wr=0, frame_len=0, frame_done=0, crc_ok=0, frame_err=0, busy=0, CRC=0xFFFFFFFF.
REQ-027 Reset mid-frame SHALL abort without frame_done; after release, data until MII_RXDV low is ignored (DROP-like) unless MII_RXDV is already low.

Verification
REQ-028 Preamble 15x0x5, 0xD, bytes "123456789" (0x31..0x39) + FCS 26 39 F4 CB, then RXDV=0 -> 13 writes at addr 0..12, frame_done, frame_len=13, crc_ok=1, frame_err=0.
REQ-029 Same frame with byte 0x35 corrupted to 0x34 -> 13 writes, frame_len=13, crc_ok=0, frame_err=1.
REQ-030 Frame with one extra nibble before RXDV falls -> 13 writes, frame_len=13, crc_ok=0, frame_err=1.
REQ-031 MAX_LEN=16, 20-byte frame -> 16 writes (addr 0..15), frame_done only after RXDV low, frame_len=16, frame_err=1.
REQ-032 Preamble 0x5,0x5,0x7 -> no writes, DROP until RXDV low, frame_done with frame_len=0, frame_err=1.
REQ-033 reset=0 asserted after byte 4 of a valid frame -> all outputs at reset values, no frame_done; next clean frame is received with crc_ok=1.
